pw_checker: RTL

//  Consumes the four stored password digits (PW0..PW3, 4-bit each, driven by the

---
 rtl/pw_pkg.sv | 21 ++
 rtl/pw_timer.sv | 27 ++
 rtl/pw_checker.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/pw_pkg.sv
// Shared definitions for the password checker: digit geometry and FSM states.
package pw_pkg;

    localparam int DIGIT_W   = 4;
    localparam int NDIG      = 4;
    localparam int MAX_DIGIT = 9;

    typedef enum logic [2:0] {
        ENTRY,
        CHECK,
        OPEN,
        ERROR,
        LOCK
    } state_t;

    // Larger of two integers, used to size the shared interval timer.
    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/pw_timer.sv
// Loadable down-counter that stops at zero; times both the open and lockout intervals.
module pw_timer #(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_value,
    output logic         zero
);

    logic [W-1:0] count;

    // Load has priority; otherwise count down and hold once zero is reached.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (count != '0) begin
            count <= count - W'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/pw_checker.sv
// Collects four keypad digits, compares them with the stored password and
// drives unlock / fail / lockout. Outputs are decoded from the registered state.
module pw_checker
    import pw_pkg::*;
#(
    parameter int MAX_FAIL    = 3,
    parameter int OPEN_CYCLES = 8,
    parameter int LOCK_CYCLES = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               key_valid,
    input  logic [DIGIT_W-1:0] key_digit,
    input  logic               key_clear,
    input  logic [DIGIT_W-1:0] PW0,
    input  logic [DIGIT_W-1:0] PW1,
    input  logic [DIGIT_W-1:0] PW2,
    input  logic [DIGIT_W-1:0] PW3,
    output logic               unlock,
    output logic               fail,
    output logic               locked,
    output logic [2:0]         digit_cnt,
    output logic [3:0]         fail_cnt
);

    localparam int TMR_W = $clog2(max_int(OPEN_CYCLES, LOCK_CYCLES)) + 1;
    localparam int IDX_W = $clog2(NDIG);

    localparam logic [TMR_W-1:0] OPEN_LOAD = TMR_W'(OPEN_CYCLES - 1);
    localparam logic [TMR_W-1:0] LOCK_LOAD = TMR_W'(LOCK_CYCLES - 1);

    state_t             state;
    state_t             state_nxt;
    logic [DIGIT_W-1:0] digit_buf [NDIG];
    logic               key_ok;
    logic               entry_full;
    logic               match;
    logic [3:0]         fail_inc;
    logic               tmr_load;
    logic [TMR_W-1:0]   tmr_load_val;
    logic               tmr_zero;

    assign key_ok     = key_valid && (key_digit <= DIGIT_W'(MAX_DIGIT));
    assign entry_full = (digit_cnt == 3'(NDIG));
    assign match      = (digit_buf[0] == PW0) && (digit_buf[1] == PW1) &&
                        (digit_buf[2] == PW2) && (digit_buf[3] == PW3);
    assign fail_inc   = (fail_cnt == 4'hF) ? 4'hF : fail_cnt + 4'd1;

    pw_timer #(
        .W(TMR_W)
    ) u_timer (
        .clk       (clk),
        .rst       (rst),
        .load      (tmr_load),
        .load_value(tmr_load_val),
        .zero      (tmr_zero)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ENTRY;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic, timer loads and Moore output decode.
    always_comb begin
        state_nxt    = state;
        unlock       = 1'b0;
        fail         = 1'b0;
        locked       = 1'b0;
        tmr_load     = 1'b0;
        tmr_load_val = '0;
        case (state)
            ENTRY: begin
                if (entry_full) begin
                    state_nxt = CHECK;
                end
            end
            CHECK: begin
                if (match) begin
                    state_nxt    = OPEN;
                    tmr_load     = 1'b1;
                    tmr_load_val = OPEN_LOAD;
                end else begin
                    state_nxt = ERROR;
                end
            end
            OPEN: begin
                unlock = 1'b1;
                if (tmr_zero) begin
                    state_nxt = ENTRY;
                end
            end
            ERROR: begin
                fail = 1'b1;
                if (fail_inc == 4'(MAX_FAIL)) begin
                    state_nxt    = LOCK;
                    tmr_load     = 1'b1;
                    tmr_load_val = LOCK_LOAD;
                end else begin
                    state_nxt = ENTRY;
                end
            end
            LOCK: begin
                locked = 1'b1;
                if (tmr_zero) begin
                    state_nxt = ENTRY;
                end
            end
            default: begin
                state_nxt = ENTRY;
            end
        endcase
    end

    // Digit buffer and counters; a full entry is frozen until CHECK consumes it.
    always_ff @(posedge clk) begin
        if (rst) begin
            digit_cnt <= '0;
            fail_cnt  <= '0;
            for (int i = 0; i < NDIG; i++) begin
                digit_buf[i] <= '0;
            end
        end else begin
            case (state)
                ENTRY: begin
                    if (!entry_full) begin
                        if (key_clear) begin
                            digit_cnt <= '0;
                        end else if (key_ok) begin
                            digit_buf[digit_cnt[IDX_W-1:0]] <= key_digit;
                            digit_cnt <= digit_cnt + 3'd1;
                        end
                    end
                end
                CHECK: begin
                    digit_cnt <= '0;
                    if (match) begin
                        fail_cnt <= '0;
                    end
                end
                ERROR: begin
                    fail_cnt <= fail_inc;
                end
                LOCK: begin
                    if (tmr_zero) begin
                        fail_cnt <= '0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
